// File: rtl/dmem_responder_pkg.sv
// Shared access-type codes and lane helpers for the data-memory responder.
// Used by dmem_responder (which honours the DMEM_MISALIGN_TRAP_EN build macro).
package dmem_responder_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  // Halfwords use off[1] only and words ignore off, so an unaligned request lands aligned.
  function automatic logic [3:0] lane_enables(input logic [2:0] dm, input logic [1:0] off);
    case (dm)
      DM_HALF, DM_HALF_U: return off[1] ? 4'b1100 : 4'b0011;
      DM_BYTE, DM_BYTE_U: return 4'b0001 << off;
      default:            return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [2:0] dm, input logic [31:0] d);
    case (dm)
      DM_HALF, DM_HALF_U: return {2{d[15:0]}};
      DM_BYTE, DM_BYTE_U: return {4{d[7:0]}};
      default:            return d;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] dm, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (dm)
      DM_HALF:   return {{16{h[15]}}, h};
      DM_HALF_U: return {16'h0000, h};
      DM_BYTE:   return {{24{b[7]}}, b};
      DM_BYTE_U: return {24'h000000, b};
      default:   return word;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] dm, input logic [1:0] off);
    case (dm)
      DM_HALF, DM_HALF_U: return off[0];
      DM_BYTE, DM_BYTE_U: return 1'b0;
      default:            return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and a
// registered read port. Contents are not reset.
module dmem_bram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // One byte-wide array per lane keeps each lane a plain write-enabled RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i && be_i[gi]) begin
        mem_q[addr_i] <= wdata_i[8*gi +: 8];
      end
      if (re_i) begin
        rd_q <= mem_q[addr_i];
      end
    end

    assign rdata_o[8*gi +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: IDLE/ACCESS/RESP handshake around dmem_bram.
// Build macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into flagged no-ops.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [2:0]  DMType,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic        misalign
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            dm_q;
  logic                  write_q;
  logic                  ready_q;
  logic                  mis_q;
  logic [31:0]           data_out_q;

  logic        last_access;
  logic        mis_d;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] data_out_d;
  logic        unused_addr;

  assign unused_addr = &{1'b0, Addr_in[31:ADDR_WIDTH+2]};

  assign last_access = (state_q == S_ACCESS) && (cnt_q == '0);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_d = is_misaligned(dm_q, addr_q[1:0]);
`else
  assign mis_d = 1'b0;
`endif

  assign ram_we    = last_access && write_q && !mis_d;
  assign ram_be    = lane_enables(dm_q, addr_q[1:0]);
  assign ram_wdata = replicate_store(dm_q, wdata_q);

  dmem_bram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bram (
    .clk    (clk),
    .re_i   (state_q == S_ACCESS),
    .we_i   (ram_we),
    .be_i   (ram_be),
    .addr_i (addr_q[ADDR_WIDTH+1:2]),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // The RAM read register is the load capture; format it during RESP, then hold.
  assign data_out_d = (write_q || mis_q) ? 32'h0 : format_load(dm_q, addr_q[1:0], ram_rdata);
  assign Data_out   = (state_q == S_RESP) ? data_out_d : data_out_q;
  assign MIO_ready  = ready_q;
  assign misalign   = mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dm_q       <= DM_WORD;
      write_q    <= 1'b0;
      ready_q    <= 1'b0;
      mis_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          mis_q   <= 1'b0;
          if (mem_r || mem_w) begin
            addr_q  <= Addr_in[ADDR_WIDTH+1:0];
            wdata_q <= Data_in;
            dm_q    <= DMType;
            write_q <= mem_w;
            cnt_q   <= WAIT_INIT;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            ready_q <= 1'b1;
            mis_q   <= mis_d;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          ready_q    <= 1'b0;
          mis_q      <= 1'b0;
          data_out_q <= data_out_d;
          state_q    <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          mis_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) checked every cycle
// against a byte-array memory model with a request timeline, plus literal pins.
module tb_dmem_responder;

  localparam int AW     = 4;
  localparam int NBYTES = 4 << AW;
  localparam logic [2:0] T_W = 3'd0, T_H = 3'd1, T_HU = 3'd2, T_B = 3'd3, T_BU = 3'd4;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2] = '{1'b0, 1'b0};
  logic        mem_r_s [2] = '{1'b0, 1'b0};
  logic        mem_w_s [2] = '{1'b0, 1'b0};
  logic [31:0] addr_s  [2] = '{32'h0, 32'h0};
  logic [31:0] data_s  [2] = '{32'h0, 32'h0};
  logic [2:0]  type_s  [2] = '{3'd0, 3'd0};

  wire  [31:0] dout_w0, dout_w1;
  wire         rdy_w0, rdy_w1, mis_w0, mis_w1;
  logic [31:0] dout_s [2];
  logic        rdy_s  [2];
  logic        mis_s  [2];

  always_comb begin
    dout_s[0] = dout_w0; dout_s[1] = dout_w1;
    rdy_s[0]  = rdy_w0;  rdy_s[1]  = rdy_w1;
    mis_s[0]  = mis_w0;  mis_s[1]  = mis_w1;
  end

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst_s[0]), .mem_r(mem_r_s[0]), .mem_w(mem_w_s[0]),
    .Addr_in(addr_s[0]), .Data_in(data_s[0]), .DMType(type_s[0]),
    .Data_out(dout_w0), .MIO_ready(rdy_w0), .misalign(mis_w0));

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst_s[1]), .mem_r(mem_r_s[1]), .mem_w(mem_w_s[1]),
    .Addr_in(addr_s[1]), .Data_in(data_s[1]), .DMType(type_s[1]),
    .Data_out(dout_w1), .MIO_ready(rdy_w1), .misalign(mis_w1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          wv     [2] = '{0, 3};
  logic [7:0]  mb     [2][NBYTES];
  bit          pend   [2] = '{1'b0, 1'b0};
  int          done_e [2] = '{0, 0};
  int          free_e [2] = '{0, 0};
  bit          m_wr   [2];
  logic [2:0]  m_t    [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_d    [2];
  logic        exp_rdy  [2] = '{1'b0, 1'b0};
  logic        exp_mis  [2] = '{1'b0, 1'b0};
  logic [31:0] exp_dout [2] = '{32'h0, 32'h0};

  task automatic model_complete(input int k);
    int ba, size, base;
    bit sgn, mis;
    logic [31:0] v;
    ba = int'(m_a[k] & 32'(NBYTES - 1));
    case (m_t[k])
      3'd1, 3'd2: size = 2;
      3'd3, 3'd4: size = 1;
      default:    size = 4;
    endcase
    sgn  = (m_t[k] == 3'd1) || (m_t[k] == 3'd3);
    mis  = TRAP && (ba % size != 0);
    base = ba - (ba % size);
    v    = 32'h0;
    if (m_wr[k]) begin
      if (!mis) for (int i = 0; i < size; i++) mb[k][base + i] = m_d[k][8*i +: 8];
    end else if (!mis) begin
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[k][base + i];
      if (sgn && v[8*size - 1]) for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    exp_dout[k] = v;
    exp_mis[k]  = mis;
    exp_rdy[k]  = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_s[k]) begin
        pend[k] = 1'b0; free_e[k] = 0;
        exp_rdy[k] = 1'b0; exp_mis[k] = 1'b0; exp_dout[k] = 32'h0;
      end else begin
        if (exp_rdy[k]) begin exp_rdy[k] = 1'b0; exp_mis[k] = 1'b0; end
        if (pend[k] && cyc == done_e[k]) begin
          model_complete(k);
          pend[k]   = 1'b0;
          free_e[k] = cyc + 2;
        end else if (!pend[k] && cyc >= free_e[k] && (mem_r_s[k] || mem_w_s[k])) begin
          pend[k] = 1'b1;
          m_wr[k] = mem_w_s[k]; m_t[k] = type_s[k]; m_a[k] = addr_s[k]; m_d[k] = data_s[k];
          done_e[k] = cyc + wv[k] + 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d_ready", k), {31'b0, rdy_s[k]}, {31'b0, exp_rdy[k]});
        chk($sformatf("d%0d_dout", k), dout_s[k], exp_dout[k]);
        if (exp_rdy[k]) chk($sformatf("d%0d_misalign", k), {31'b0, mis_s[k]}, {31'b0, exp_mis[k]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input int k, input bit wr, input bit both, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] dout, output int lat, output logic mis);
    repeat (2) @(negedge clk);
    mem_r_s[k] = !wr || both; mem_w_s[k] = wr;
    type_s[k] = t; addr_s[k] = a; data_s[k] = d;
    lat = 0; dout = 32'h0; mis = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #3;
      if (rdy_s[k]) begin lat = n; dout = dout_s[k]; mis = mis_s[k]; break; end
    end
    mem_r_s[k] = 1'b0; mem_w_s[k] = 1'b0;
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL d%0d_handshake: got no MIO_ready want pulse within 60 cycles", k);
    end
    $display("txn dut%0d %s type=%0d addr=%h data=%h dout=%h lat=%0d mis=%0b",
             k, wr ? "st" : "ld", t, a, d, dout, lat, mis);
  endtask

  logic [31:0] rd;
  int          lat, np, first, prev;
  logic        mis;

  initial begin
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    @(posedge clk); #3;
    chk("rst_dout0", dout_s[0], 32'h0);
    chk("rst_dout1", dout_s[1], 32'h0);
    chk("rst_ready0", {31'b0, rdy_s[0]}, 32'h0);
    chk("rst_misalign1", {31'b0, mis_s[1]}, 32'h0);

    // zero wait states
    access(0, 1, 0, T_W, 32'h10, 32'hDEADBEEF, rd, lat, mis);
    chk("w0_store_lat", lat, 2);
    access(0, 0, 0, T_W, 32'h10, 32'h0, rd, lat, mis);
    chk("w0_load_lat", lat, 2);
    chk("word_roundtrip", rd, 32'hDEADBEEF);
    access(0, 1, 0, T_W, 32'h10, 32'h11223344, rd, lat, mis);
    access(0, 1, 0, T_B, 32'h13, 32'h12345680, rd, lat, mis);
    chk("byte_store_dout", rd, 32'h0);
    access(0, 0, 0, T_W, 32'h10, 32'h0, rd, lat, mis);
    chk("byte_merge_word", rd, 32'h80223344);
    access(0, 0, 0, T_B, 32'h13, 32'h0, rd, lat, mis);
    chk("byte_signed", rd, 32'hFFFFFF80);
    access(0, 0, 0, T_BU, 32'h13, 32'h0, rd, lat, mis);
    chk("byte_unsigned", rd, 32'h00000080);
    access(0, 1, 0, T_W, 32'h20, 32'h55667788, rd, lat, mis);
    access(0, 1, 0, T_H, 32'h22, 32'hBEEFA5C3, rd, lat, mis);
    access(0, 0, 0, T_H, 32'h22, 32'h0, rd, lat, mis);
    chk("half_signed", rd, 32'hFFFFA5C3);
    access(0, 0, 0, T_HU, 32'h22, 32'h0, rd, lat, mis);
    chk("half_unsigned", rd, 32'h0000A5C3);
    access(0, 0, 0, T_W, 32'h20, 32'h0, rd, lat, mis);
    chk("half_merge_word", rd, 32'hA5C37788);
    access(0, 1, 0, T_W, 32'h21, 32'h12345678, rd, lat, mis);
    chk("misalign_flag", {31'b0, mis}, {31'b0, TRAP});
    access(0, 0, 0, T_W, 32'h20, 32'h0, rd, lat, mis);
    chk("misalign_mem", rd, TRAP ? 32'hA5C37788 : 32'h12345678);
    access(0, 0, 0, T_W, 32'h150, 32'h0, rd, lat, mis);
    chk("addr_wrap", rd, 32'h80223344);

    // three wait states
    access(1, 1, 0, T_W, 32'h30, 32'hCAFEF00D, rd, lat, mis);
    chk("w3_store_lat", lat, 5);
    access(1, 0, 0, T_W, 32'h30, 32'h0, rd, lat, mis);
    chk("w3_load_lat", lat, 5);
    chk("w3_load", rd, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    mem_r_s[1] = 1'b1; type_s[1] = T_W; addr_s[1] = 32'h30;
    np = 0; first = 0; prev = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #3;
      if (rdy_s[1]) begin
        if (np == 0) first = n;
        else chk("hold_gap", n - prev, 6);
        prev = n; np++;
      end
    end
    @(negedge clk);
    mem_r_s[1] = 1'b0;
    repeat (12) @(negedge clk);
    chk("hold_first", first, 5);
    chk("hold_pulses", np, 6);

    // reset two cycles into a store
    repeat (2) @(negedge clk);
    mem_w_s[1] = 1'b1; type_s[1] = T_W; addr_s[1] = 32'h30; data_s[1] = 32'h0BADBEEF;
    np = 0;
    repeat (2) begin @(posedge clk); #3; if (rdy_s[1]) np++; end
    @(negedge clk);
    rst_s[1] = 1'b0;
    repeat (2) begin @(posedge clk); #3; if (rdy_s[1]) np++; end
    chk("abort_dout", dout_s[1], 32'h0);
    @(negedge clk);
    mem_w_s[1] = 1'b0;
    rst_s[1] = 1'b1;
    repeat (6) begin @(posedge clk); #3; if (rdy_s[1]) np++; end
    chk("abort_no_ready", np, 0);
    access(1, 0, 0, T_W, 32'h30, 32'h0, rd, lat, mis);
    chk("abort_mem_kept", rd, 32'hCAFEF00D);
    access(1, 1, 0, T_W, 32'h30, 32'h600DD00D, rd, lat, mis);
    access(1, 0, 0, T_W, 32'h30, 32'h0, rd, lat, mis);
    chk("post_reset_store", rd, 32'h600DD00D);

    // randomized traffic, every word written first so loads are defined
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < NBYTES / 4; w++)
        access(k, 1, 0, T_W, 32'(w * 4), $urandom, rd, lat, mis);
      for (int i = 0; i < 100; i++) begin
        bit wr, both;
        both = ($urandom_range(0, 9) == 0);
        wr   = both || ($urandom_range(0, 1) == 1);
        access(k, wr, both, 3'($urandom_range(0, 7)), $urandom, $urandom, rd, lat, mis);
      end
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
